// File: rtl/truth_table_probe_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_probe_pkg
// Shared types and constants for the truth-table probe.
//   state_t               : sweep controller states
//   tt_width()            : truth-word width for a given input count
//   DEFAULT_SETTLE_CYCLES : default per-row settle time
// ---------------------------------------------------------------------------
package truth_table_probe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_SETTLE_CYCLES = 4;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/probe_settle_timer.sv
// ---------------------------------------------------------------------------
// probe_settle_timer
// Load/expire down-counter that paces each truth-table row.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : load count_init this edge (takes priority over counting)
//   count_init  : value loaded on load
//   expire      : high while the count has reached zero
// After a load of N, expire rises N edges later, so a row that reloads on
// expire lasts N+1 cycles.
// ---------------------------------------------------------------------------
module probe_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] count_init,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = count_init;
        end else if (!expire) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_probe.sv
// ---------------------------------------------------------------------------
// truth_table_probe
// Sweeps every input combination into a combinational netlist, holds each row
// SETTLE_CYCLES+1 cycles, samples the netlist output and packs the results
// MSB-first into a truth word (row 0 lands in bit TT_W-1).
//   clk, rst_n : clock, synchronous active-low reset (aborts any sweep)
//   start      : begin a sweep (only honoured when idle)
//   busy       : sweep in progress
//   stim       : netlist input vector; stim[N_IN-1] is in1
//   resp       : netlist output
//   tt_word    : assembled truth table, kept until the next sweep completes
//   tt_valid   : tt_word ready, held until tt_ready
//   tt_ready   : consumer acknowledge
// Optional (macro TRUTH_TABLE_PROBE_CHECK_EN):
//   expected_tt        : reference word, captured when start is accepted
//   match              : tt_word == expected_tt
//   first_mismatch_row : lowest differing row, 0 on match
// ---------------------------------------------------------------------------
module truth_table_probe
    import truth_table_probe_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    localparam int TT_W         = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic [TT_W-1:0] tt_word,
    output logic            tt_valid,
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
    input  logic [TT_W-1:0] expected_tt,
    output logic            match,
    output logic [N_IN-1:0] first_mismatch_row,
`endif
    input  logic            tt_ready
);

    localparam int          ROW_W    = N_IN + 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TT_W - 1);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [TT_W-2:0]   shift_q, shift_d;
    logic [TT_W-1:0]   tt_word_q, tt_word_d;
    logic [TT_W-1:0]   final_word;
    logic              timer_load;
    logic              timer_expire;

    probe_settle_timer #(
        .CNT_W (8)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .count_init (8'(SETTLE_CYCLES)),
        .expire     (timer_expire)
    );

    // Word as it stands once the current resp bit is shifted in; on the last
    // row this is the finished truth table.
    assign final_word = {shift_q, resp};

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        shift_d    = shift_q;
        tt_word_d  = tt_word_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SWEEP;
                    row_d      = '0;
                    shift_d    = '0;
                    timer_load = 1'b1;
                end
            end
            SWEEP: begin
                if (timer_expire) begin
                    shift_d    = final_word[TT_W-2:0];
                    timer_load = 1'b1;
                    if (row_q == ROW_LAST) begin
                        tt_word_d = final_word;
                        state_d   = HOLD;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tt_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            shift_q   <= '0;
            tt_word_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            shift_q   <= shift_d;
            tt_word_q <= tt_word_d;
        end
    end

    assign busy     = (state_q == SWEEP);
    assign tt_valid = (state_q == HOLD);
    assign stim     = (state_q == SWEEP) ? row_q[N_IN-1:0] : '0;
    assign tt_word  = tt_word_q;

`ifdef TRUTH_TABLE_PROBE_CHECK_EN
    logic [TT_W-1:0] expected_q, expected_d;
    logic            match_q, match_d;
    logic [N_IN-1:0] mis_row_q, mis_row_d;
    logic [TT_W-1:0] diff;

    assign diff = final_word ^ expected_q;

    always_comb begin
        expected_d = expected_q;
        match_d    = match_q;
        mis_row_d  = mis_row_q;
        if (state_q == IDLE && start) begin
            expected_d = expected_tt;
        end
        if (state_q == SWEEP && timer_expire && row_q == ROW_LAST) begin
            match_d   = (diff == '0);
            mis_row_d = '0;
            // Higher bit index = lower row; the last hit wins, giving the
            // lowest differing row.
            for (int i = 0; i < TT_W; i++) begin
                if (diff[i]) begin
                    mis_row_d = N_IN'(TT_W - 1 - i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            expected_q <= '0;
            match_q    <= 1'b0;
            mis_row_q  <= '0;
        end else begin
            expected_q <= expected_d;
            match_q    <= match_d;
            mis_row_q  <= mis_row_d;
        end
    end

    assign match              = match_q;
    assign first_mismatch_row = mis_row_q;
`endif

endmodule

// File: tb/tb_truth_table_probe.sv
module tb_truth_table_probe;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Instance 0: defaults (N_IN=4, SETTLE_CYCLES=4)
    logic        start0, busy0, resp0, tt_valid0, ready0;
    logic [3:0]  stim0;
    logic [15:0] tt_word0;
    int          mode;
    logic [15:0] f_tt = 16'h2A56;

    // Behavioural netlist models selected by mode
    always_comb begin
        case (mode)
            0:       resp0 = f_tt[~stim0];   // row r -> bit 15-r
            1:       resp0 = stim0[3];       // in1
            2:       resp0 = stim0[0];       // in4
            3:       resp0 = 1'b0;
            default: resp0 = 1'b1;
        endcase
    end

    // Instance 1: N_IN=2, SETTLE_CYCLES=0, AND gate
    logic        start1, busy1, resp1, tt_valid1, ready1;
    logic [1:0]  stim1;
    logic [3:0]  tt_word1;
    assign resp1 = stim1[1] & stim1[0];

`ifdef TRUTH_TABLE_PROBE_CHECK_EN
    logic [15:0] exp0;
    logic        match0, match1;
    logic [3:0]  fmr0;
    logic [1:0]  fmr1;
`endif

    truth_table_probe dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .busy     (busy0),
        .stim     (stim0),
        .resp     (resp0),
        .tt_word  (tt_word0),
        .tt_valid (tt_valid0),
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
        .expected_tt        (exp0),
        .match              (match0),
        .first_mismatch_row (fmr0),
`endif
        .tt_ready (ready0)
    );

    truth_table_probe #(.N_IN(2), .SETTLE_CYCLES(0)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .busy     (busy1),
        .stim     (stim1),
        .resp     (resp1),
        .tt_word  (tt_word1),
        .tt_valid (tt_valid1),
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
        .expected_tt        (4'h1),
        .match              (match1),
        .first_mismatch_row (fmr1),
`endif
        .tt_ready (ready1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut0 and wait for tt_valid; returns edges after E0 and
    // number of cycles busy was seen high (E0 included).
    task automatic sweep0(output int lat, output int busy_n);
        start0 = 1'b1;
        tick();            // E0
        start0 = 1'b0;
        lat    = 0;
        busy_n = busy0 ? 1 : 0;
        while (!tt_valid0 && lat < 300) begin
            tick();
            lat++;
            if (busy0) busy_n++;
        end
        check("sweep_done", {31'd0, tt_valid0}, 32'd1);
    endtask

    task automatic handshake0();
        ready0 = 1'b1;
        tick();
        ready0 = 1'b0;
        check("hs_valid_low", {31'd0, tt_valid0}, 32'd0);
    endtask

    typedef struct {
        int          mode;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat, bn;

        vecs[0] = '{0, 16'h2A56, "f_2a56"};
        vecs[1] = '{1, 16'h00FF, "in1"};
        vecs[2] = '{2, 16'h5555, "in4"};
        vecs[3] = '{3, 16'h0000, "tied0"};
        vecs[4] = '{4, 16'hFFFF, "tied1"};

        rst_n = 1'b0; start0 = 1'b0; ready0 = 1'b0;
        start1 = 1'b0; ready1 = 1'b0; mode = 0;
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
        exp0 = 16'h0;
`endif
        repeat (3) tick();
        check("rst_busy",   {31'd0, busy0}, 32'd0);
        check("rst_valid",  {31'd0, tt_valid0}, 32'd0);
        check("rst_stim",   {28'd0, stim0}, 32'd0);
        check("rst_word",   {16'd0, tt_word0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven sweeps
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            sweep0(lat, bn);
            check(vecs[i].name, {16'd0, tt_word0}, {16'd0, vecs[i].exp});
            if (i == 0) begin
                check("latency", lat, 80);
                check("busy_cycles", bn, 80);
                check("done_stim", {28'd0, stim0}, 32'd0);
            end
            handshake0();
        end

        // Reset mid-sweep during row 7 (rows last 5 edges, row 7 = E0+35..39)
        mode = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (37) tick();
        check("row7_stim", {28'd0, stim0}, 32'd7);
        check("row7_busy", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_stim",  {28'd0, stim0}, 32'd0);
        check("abort_busy",  {31'd0, busy0}, 32'd0);
        check("abort_valid", {31'd0, tt_valid0}, 32'd0);
        rst_n = 1'b1;
        tick();
        sweep0(lat, bn);
        check("after_abort", {16'd0, tt_word0}, 32'h2A56);
        check("after_abort_lat", lat, 80);

        // HOLD with tt_ready low and start pulses
        for (int k = 0; k < 20; k++) begin
            start0 = k[0];
            tick();
            check("hold_valid", {31'd0, tt_valid0}, 32'd1);
            check("hold_busy",  {31'd0, busy0}, 32'd0);
            check("hold_word",  {16'd0, tt_word0}, 32'h2A56);
        end
        // start with tt_ready: handshake wins, start ignored
        start0 = 1'b1;
        ready0 = 1'b1;
        tick();
        start0 = 1'b0;
        ready0 = 1'b0;
        check("hs_start_valid", {31'd0, tt_valid0}, 32'd0);
        check("hs_start_busy",  {31'd0, busy0}, 32'd0);
        tick();
        check("no_queue_busy", {31'd0, busy1 | busy0}, 32'd0);
        check("word_kept", {16'd0, tt_word0}, 32'h2A56);

        // N_IN=2, SETTLE_CYCLES=0: one cycle per row
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            check("s0_stim", {30'd0, stim1}, r);
            check("s0_busy", {31'd0, busy1}, 32'd1);
            tick();
        end
        check("s0_valid", {31'd0, tt_valid1}, 32'd1);
        check("s0_word",  {28'd0, tt_word1}, 32'h1);
        check("s0_stim_done", {30'd0, stim1}, 32'd0);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        check("s0_hs", {31'd0, tt_valid1}, 32'd0);

`ifdef TRUTH_TABLE_PROBE_CHECK_EN
        mode = 0;
        exp0 = 16'h2A57;
        sweep0(lat, bn);
        check("chk_match0", {31'd0, match0}, 32'd0);
        check("chk_row15",  {28'd0, fmr0}, 32'd15);
        handshake0();
        exp0 = 16'h2A56;
        sweep0(lat, bn);
        check("chk_match1", {31'd0, match0}, 32'd1);
        check("chk_row0",   {28'd0, fmr0}, 32'd0);
        handshake0();
        check("chk_and_match", {31'd0, match1}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
